// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared constants and types for the fetch front end.
//   XLEN          default datapath / address width
//   NOP_INSTR     canonical bubble instruction (addi x0, x0, 0)
//   fetch_state_t fetch FSM states
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // FETCH: request outstanding on the current PC
  // HOLD : a fetched word is parked because IF/ID is frozen
  // KILL : waiting out a request whose response must be discarded
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register with write enable and bubble insertion.
//   Priority: reset > bubble > writeEn.
// Ports
//   clk, reset         clock, synchronous active-high reset
//   writeEn            load pcIn/instrIn and mark valid
//   bubble             replace contents with a NOP bubble (PC kept)
//   pcIn, instrIn      incoming fetch result
//   pcOut, instrOut    registered PC / instruction
//   validOut           1 = real instruction, 0 = bubble
module if_id_reg #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            writeEn,
  input  logic            bubble,
  input  logic [XLEN-1:0] pcIn,
  input  logic [31:0]     instrIn,
  output logic [XLEN-1:0] pcOut,
  output logic [31:0]     instrOut,
  output logic            validOut
);
  import riscv_pkg::*;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcOut    <= '0;
      instrOut <= NOP_INSTR;
      validOut <= 1'b0;
    end else if (bubble) begin
      instrOut <= NOP_INSTR;
      validOut <= 1'b0;
    end else if (writeEn) begin
      pcOut    <= pcIn;
      instrOut <= instrIn;
      validOut <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch: PC register, fetch FSM, one-entry hold buffer and the
//   IF/ID register. Talks to a variable-latency instruction memory through a
//   req/ready handshake and obeys PCWrite / IF_ID_Write / Flush from the
//   hazard unit plus branch redirects from EX.
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   PCWrite, IF_ID_Write        stall controls (0 = freeze)
//   Flush                       squash IF/ID and any pending fetch
//   BranchTaken, BranchTarget   redirect from EX
//   imem_req, imem_addr         fetch request / address
//   imem_ready, imem_rdata      memory response handshake / data
//   IF_ID_PC, IF_ID_Instr       contents of IF/ID
//   IF_ID_Valid                 IF/ID holds a real instruction
//   FetchStall                  front end waiting on memory this cycle
module fetch_stage #(
  parameter int                         XLEN     = riscv_pkg::XLEN,
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC = '0,
  parameter int                         PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCWrite,
  input  logic            IF_ID_Write,
  input  logic            Flush,
  input  logic            BranchTaken,
  input  logic [XLEN-1:0] BranchTarget,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [31:0]     IF_ID_Instr,
  output logic            IF_ID_Valid,
  output logic            FetchStall
);
  import riscv_pkg::*;

  fetch_state_t    stateReg, stateNext;
  logic [XLEN-1:0] pcReg, pcNext;
  logic [XLEN-1:0] killAddrReg, killAddrNext;
  logic [XLEN-1:0] holdPcReg, holdPcNext;
  logic [31:0]     holdInstrReg, holdInstrNext;

  logic            accept;
  logic            redirect;
  logic [XLEN-1:0] pcInc;
  logic            ifIdWe;
  logic            ifIdBubble;
  logic [XLEN-1:0] ifIdPcIn;
  logic [31:0]     ifIdInstrIn;

  assign accept   = imem_req & imem_ready;
  assign redirect = BranchTaken | Flush;
  // Wraps modulo 2^XLEN naturally.
  assign pcInc    = pcReg + XLEN'(PC_STEP);

  // State register together with the PC, kill address and hold buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= FETCH;
      pcReg        <= RESET_PC;
      killAddrReg  <= RESET_PC;
      holdPcReg    <= '0;
      holdInstrReg <= NOP_INSTR;
    end else begin
      stateReg     <= stateNext;
      pcReg        <= pcNext;
      killAddrReg  <= killAddrNext;
      holdPcReg    <= holdPcNext;
      holdInstrReg <= holdInstrNext;
    end
  end

  // Next-state logic. A request still waiting on memory cannot be withdrawn,
  // so a redirect during an unanswered request goes (or stays) in KILL.
  always_comb begin
    stateNext = stateReg;
    if (redirect) begin
      if ((stateReg != HOLD) && !accept) stateNext = KILL;
      else                               stateNext = FETCH;
    end else begin
      case (stateReg)
        FETCH:   if (accept && !IF_ID_Write) stateNext = HOLD;
        HOLD:    if (IF_ID_Write)            stateNext = FETCH;
        KILL:    if (accept)                 stateNext = FETCH;
        default:                             stateNext = FETCH;
      endcase
    end
  end

  // Outputs. No request in the reset cycle; KILL keeps presenting the
  // abandoned address so the memory sees a stable request.
  always_comb begin
    imem_req   = !reset && (stateReg != HOLD);
    imem_addr  = (stateReg == KILL) ? killAddrReg : pcReg;
    FetchStall = !reset && (((stateReg == FETCH) && !imem_ready) || (stateReg == KILL));
  end

  // Datapath: PC update, hold buffer capture and IF/ID control.
  always_comb begin
    pcNext        = pcReg;
    killAddrNext  = killAddrReg;
    holdPcNext    = holdPcReg;
    holdInstrNext = holdInstrReg;
    ifIdWe        = 1'b0;
    ifIdBubble    = 1'b0;
    ifIdPcIn      = pcReg;
    ifIdInstrIn   = imem_rdata;
    if (redirect) begin
      if (BranchTaken) pcNext = BranchTarget;
      ifIdBubble    = 1'b1;
      holdPcNext    = '0;
      holdInstrNext = NOP_INSTR;
      if ((stateReg == FETCH) && !accept) killAddrNext = pcReg;
    end else begin
      case (stateReg)
        FETCH: begin
          if (accept) begin
            if (IF_ID_Write) begin
              ifIdWe = 1'b1;
              if (PCWrite) pcNext = pcInc;
            end else begin
              // IF/ID frozen: park the word so it is neither lost nor refetched.
              holdPcNext    = pcReg;
              holdInstrNext = imem_rdata;
            end
          end else if (IF_ID_Write) begin
            ifIdBubble = 1'b1;
          end
        end
        HOLD: begin
          if (IF_ID_Write) begin
            ifIdWe      = 1'b1;
            ifIdPcIn    = holdPcReg;
            ifIdInstrIn = holdInstrReg;
            if (PCWrite) pcNext = pcInc;
          end
        end
        KILL: begin
          if (IF_ID_Write) ifIdBubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  if_id_reg #(.XLEN(XLEN)) ifIdRegInst (
    .clk      (clk),
    .reset    (reset),
    .writeEn  (ifIdWe),
    .bubble   (ifIdBubble),
    .pcIn     (ifIdPcIn),
    .instrIn  (ifIdInstrIn),
    .pcOut    (IF_ID_PC),
    .instrOut (IF_ID_Instr),
    .validOut (IF_ID_Valid)
  );

endmodule
